// File: rtl/pipe_chain_if.sv
// Handshake and payload bundle for pipe_chain.
// Perf counter signals exist only when PIPE_CHAIN_PERF_EN is defined.
interface pipe_chain_if #(
    parameter int STAGES = 5,
    parameter int DATA_W = 64
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_allowin;
    logic [STAGES-1:0]        ready_go;
    logic [STAGES-1:0]        flush;
    logic                     out_allowin;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0]              perf_retire;
    logic [31:0]              perf_stall;
    logic [31:0]              perf_flush;

    modport slave (
        input  in_valid, in_data, ready_go, flush, out_allowin,
        output in_allowin, out_valid, out_data, stage_valid, stage_data,
        output perf_retire, perf_stall, perf_flush
    );
    modport master (
        output in_valid, in_data, ready_go, flush, out_allowin,
        input  in_allowin, out_valid, out_data, stage_valid, stage_data,
        input  perf_retire, perf_stall, perf_flush
    );
`else
    modport slave (
        input  in_valid, in_data, ready_go, flush, out_allowin,
        output in_allowin, out_valid, out_data, stage_valid, stage_data
    );
    modport master (
        output in_valid, in_data, ready_go, flush, out_allowin,
        input  in_allowin, out_valid, out_data, stage_valid, stage_data
    );
`endif
endinterface

// File: rtl/pipe_chain.sv
// N-stage valid/allowin pipeline skeleton with back-pressure and flush-kill of younger stages.
// Optional perf counters are enabled by defining PIPE_CHAIN_PERF_EN.
module pipe_chain #(
    parameter int STAGES = 5,
    parameter int DATA_W = 64
) (
    input  logic        clk,
    input  logic        resetn,
    pipe_chain_if.slave pif
);
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             valid_d;
    logic [STAGES-1:0][DATA_W-1:0] data_q;
    logic [STAGES-1:0][DATA_W-1:0] data_d;
    logic [STAGES-1:0]             allowin_s;
    logic [STAGES-1:0]             to_next_s;
    logic [STAGES-1:0]             kill_s;
    logic                          kill_in_s;

    // Allowin chain and kill mask, walked from the oldest stage down to the youngest.
    always_comb begin : chain_comb
        logic allow_v;
        logic older_flush_v;
        allow_v       = pif.out_allowin;
        older_flush_v = 1'b0;
        allowin_s     = {STAGES{1'b0}};
        to_next_s     = {STAGES{1'b0}};
        kill_s        = {STAGES{1'b0}};
        for (int i = STAGES - 1; i >= 0; i--) begin
            to_next_s[i]  = valid_q[i] & pif.ready_go[i];
            allow_v       = ~valid_q[i] | (pif.ready_go[i] & allow_v);
            allowin_s[i]  = allow_v;
            // A stage dies when any strictly older stage redirects.
            kill_s[i]     = older_flush_v;
            older_flush_v = older_flush_v | pif.flush[i];
        end
        kill_in_s = |pif.flush;
    end

    // Per-stage load/hold; killed stages and killed hand-offs are forced invalid.
    always_comb begin : next_comb
        valid_d = valid_q;
        data_d  = data_q;
        if (allowin_s[0]) begin
            valid_d[0] = pif.in_valid & ~kill_in_s;
            if (pif.in_valid & ~kill_in_s) begin
                data_d[0] = pif.in_data;
            end else begin
                data_d[0] = data_q[0];
            end
        end else begin
            valid_d[0] = valid_q[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            if (allowin_s[i]) begin
                valid_d[i] = to_next_s[i-1] & ~kill_s[i-1];
                if (to_next_s[i-1]) begin
                    data_d[i] = data_q[i-1];
                end else begin
                    data_d[i] = data_q[i];
                end
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
        valid_d = valid_d & ~kill_s;
    end

    // Stage valid/payload registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= {STAGES{1'b0}};
            data_q  <= {(STAGES*DATA_W){1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign pif.in_allowin  = allowin_s[0] & ~kill_in_s;
    assign pif.out_valid   = to_next_s[STAGES-1];
    assign pif.out_data    = data_q[STAGES-1];
    assign pif.stage_valid = valid_q;
    assign pif.stage_data  = data_q;

`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0] perf_retire_q;
    logic [31:0] perf_retire_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_flush_d;

    // Event counters; they wrap naturally at 2^32.
    always_comb begin : perf_comb
        perf_retire_d = perf_retire_q;
        perf_stall_d  = perf_stall_q;
        perf_flush_d  = perf_flush_q;
        if (to_next_s[STAGES-1] & pif.out_allowin) begin
            perf_retire_d = perf_retire_q + 32'd1;
        end else begin
            perf_retire_d = perf_retire_q;
        end
        if (valid_q[0] & ~allowin_s[0]) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (kill_in_s) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end else begin
            perf_flush_d = perf_flush_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_retire_q <= 32'd0;
            perf_stall_q  <= 32'd0;
            perf_flush_q  <= 32'd0;
        end else begin
            perf_retire_q <= perf_retire_d;
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
        end
    end

    assign pif.perf_retire = perf_retire_q;
    assign pif.perf_stall  = perf_stall_q;
    assign pif.perf_flush  = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: accepted payloads are queued and matched against retirements.
module tb_pipe_chain;
    localparam int STAGES = 5;
    localparam int DATA_W = 64;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                edge_in;
    } sb_item_t;

    logic     clk = 1'b0;
    logic     resetn;
    int       checks_cnt = 0;
    int       errors_cnt = 0;
    int       edge_n = 0;
    int       retire_cnt = 0;
    bit       lat_chk = 1'b0;
    sb_item_t sb_q[$];

    pipe_chain_if #(.STAGES(STAGES), .DATA_W(DATA_W)) pif ();

    pipe_chain #(.STAGES(STAGES), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .pif    (pif.slave)
    );

    always #5 clk = ~clk;

    // Edge counter for latency measurement.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        sb_item_t it;
        if (resetn) begin
            if (pif.out_valid && pif.out_allowin) begin
                retire_cnt++;
                check_val("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    it = sb_q.pop_front();
                    check_val("out_data", pif.out_data, it.data);
                    if (lat_chk) check_val("latency", 64'(edge_n - it.edge_in - 1), 64'(STAGES - 1));
                end
            end
            if (pif.in_valid && pif.in_allowin) begin
                it.data    = pif.in_data;
                it.edge_in = edge_n;
                sb_q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pif.in_valid    = 1'b0;
        pif.in_data     = 64'd0;
        pif.ready_go    = {STAGES{1'b1}};
        pif.flush       = {STAGES{1'b0}};
        pif.out_allowin = 1'b1;
    endtask

    task automatic drain(input string tag);
        idle_inputs();
        for (int i = 0; i < 30; i++) begin
            if (pif.stage_valid == {STAGES{1'b0}}) break;
            step();
        end
        check_val({tag, "_empty"}, 64'(pif.stage_valid), 64'd0);
        check_val({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic fill_stalled(input logic [63:0] base);
        pif.out_allowin = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = base + 64'(i);
            check_val("fill_in_allowin", 64'(pif.in_allowin), 64'd1);
            step();
        end
        check_val("fill_full", 64'(pif.stage_valid), 64'h1F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #12;
        resetn = 1'b1;
        step();
        check_val("rst_stage_valid", 64'(pif.stage_valid), 64'd0);
        check_val("rst_out_valid", 64'(pif.out_valid), 64'd0);
        check_val("rst_in_allowin", 64'(pif.in_allowin), 64'd1);
        check_val("rst_stage_data_zero", 64'(|pif.stage_data), 64'd0);

        // Streaming at full rate: fixed STAGES-1 edge latency.
        lat_chk = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = 64'(i);
            check_val("t1_in_allowin", 64'(pif.in_allowin), 64'd1);
            step();
        end
        drain("t1");
        lat_chk = 1'b0;

        // Consumer stall with continuous input: chain fills, then drains in order.
        pif.out_allowin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = 64'h200 + 64'(i);
            step();
        end
        check_val("t2_full", 64'(pif.stage_valid), 64'h1F);
        check_val("t2_in_allowin", 64'(pif.in_allowin), 64'd0);
        check_val("t2_out_valid", 64'(pif.out_valid), 64'd1);
        check_val("t2_sb_count", 64'(sb_q.size()), 64'd5);
        pif.out_allowin = 1'b1;
        for (int i = 8; i < 12; i++) begin
            pif.in_data = 64'h200 + 64'(i);
            step();
        end
        drain("t2");

        // Stage 2 stalls holding 0x33: older stages drain, bubble opens at 3.
        for (int i = 1; i <= 5; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = 64'h30 + 64'(i);
            step();
        end
        check_val("t3_pre_s2", pif.stage_data[2*DATA_W +: DATA_W], 64'h33);
        pif.in_valid = 1'b0;
        pif.ready_go = 5'b11011;
        step();
        check_val("t3_c1_valid", 64'(pif.stage_valid), 64'h17);
        check_val("t3_c1_s2", pif.stage_data[2*DATA_W +: DATA_W], 64'h33);
        step();
        check_val("t3_c2_valid", 64'(pif.stage_valid), 64'h07);
        step();
        check_val("t3_c3_valid", 64'(pif.stage_valid), 64'h07);
        check_val("t3_c3_s0", pif.stage_data[0 +: DATA_W], 64'h35);
        pif.ready_go = {STAGES{1'b1}};
        step();
        check_val("t3_rel_valid", 64'(pif.stage_valid), 64'h0E);
        check_val("t3_rel_s3", pif.stage_data[3*DATA_W +: DATA_W], 64'h33);
        drain("t3");

        // Flush from stage 2 on a full chain while the consumer accepts.
        fill_stalled(64'hA0);
        pif.in_valid    = 1'b1;
        pif.in_data     = 64'hAF;
        pif.out_allowin = 1'b1;
        pif.flush       = 5'b00100;
        #1;
        check_val("t4_in_allowin", 64'(pif.in_allowin), 64'd0);
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        step();
        pif.flush    = {STAGES{1'b0}};
        pif.in_valid = 1'b0;
        check_val("t4_valid", 64'(pif.stage_valid), 64'h18);
        check_val("t4_s4", pif.stage_data[4*DATA_W +: DATA_W], 64'hA2);
        check_val("t4_s3", pif.stage_data[3*DATA_W +: DATA_W], 64'hA3);
        drain("t4");

        // Two flush bits under full stall: the older one (stage 3) wins.
        fill_stalled(64'hB0);
        pif.in_valid = 1'b0;
        pif.flush    = 5'b01010;
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        step();
        pif.flush = {STAGES{1'b0}};
        check_val("t5_valid", 64'(pif.stage_valid), 64'h18);
        check_val("t5_s4", pif.stage_data[4*DATA_W +: DATA_W], 64'hB1);
        check_val("t5_s3", pif.stage_data[3*DATA_W +: DATA_W], 64'hB2);
        drain("t5");

        // flush[0] kills nothing but still refuses input.
        pif.in_valid = 1'b1;
        pif.in_data  = 64'h55;
        pif.flush    = 5'b00001;
        #1;
        check_val("t6_in_allowin", 64'(pif.in_allowin), 64'd0);
        step();
        idle_inputs();
        check_val("t6_valid", 64'(pif.stage_valid), 64'd0);

`ifdef PIPE_CHAIN_PERF_EN
        check_val("perf_retire", 64'(pif.perf_retire), 64'(retire_cnt));
        check_val("perf_flush", 64'(pif.perf_flush), 64'd3);
`endif

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = 64'h600 + 64'(i);
            step();
        end
        check_val("t7_pre_valid", 64'(pif.stage_valid), 64'h1F);
        #3;
        resetn = 1'b0;
        #1;
        check_val("t7_rst_valid", 64'(pif.stage_valid), 64'd0);
        check_val("t7_rst_out_valid", 64'(pif.out_valid), 64'd0);
`ifdef PIPE_CHAIN_PERF_EN
        check_val("t7_perf_retire", 64'(pif.perf_retire), 64'd0);
        check_val("t7_perf_stall", 64'(pif.perf_stall), 64'd0);
        check_val("t7_perf_flush", 64'(pif.perf_flush), 64'd0);
`endif
        sb_q.delete();
        idle_inputs();
        #10;
        resetn = 1'b1;
        step();
        check_val("t7_post_valid", 64'(pif.stage_valid), 64'd0);
        check_val("t7_post_in_allowin", 64'(pif.in_allowin), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
